mem_access_ctrl: RTL and testbench

- Requester-side sequencer for the single-port byte RAM: the processor core issues byte or 16-bit word read/write requests, and this block drives the RAM's address, read, write and write-data lines one byte per phase.
- Captures RAM read data and returns a single response pulse per request. Words are little-endian (low byte at addr, high byte at addr+1).
- Sits between the core's load/store unit and the RAM.

---
 rtl/mem_access_if.sv | 31 +++
 rtl/mem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// mem_access_if: core load/store request channel plus
// the single-port byte RAM bus, grouped for one port.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (
    output req_valid, req_write, req_word,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_addr, mem_read, mem_write, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_word,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences byte/word core requests onto a
// byte-wide RAM, one byte phase at a time, little-endian.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  mem_access_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam logic [3:0] LAST   = 4'(WAIT_CYCLES);
  localparam logic FIRST_WR     = (WAIT_CYCLES == 0);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        word_q, word_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        rdy_q, rdy_d;
  logic        rv_q, rv_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] ma_q, ma_d;
  logic        mr_q, mr_d;
  logic        mw_q, mw_d;
  logic [7:0]  mwd_q, mwd_d;
  logic        last;

  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    word_d  = word_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rdy_d   = rdy_q;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    ma_d    = ma_q;
    mr_d    = mr_q;
    mw_d    = 1'b0;
    mwd_d   = mwd_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        rdy_d = 1'b1;
        if (bus.req_valid && rdy_q) begin
          wr_d    = bus.req_write;
          word_d  = bus.req_word;
          addr_d  = bus.req_addr;
          hi_d    = bus.req_wdata[15:8];
          rdy_d   = 1'b0;
          state_d = S_LO;
          cnt_d   = 4'd0;
          ma_d    = bus.req_addr;
          mwd_d   = bus.req_wdata[7:0];
          mr_d    = ~bus.req_write;
          mw_d    = bus.req_write & FIRST_WR;
        end
      end
      (state_q == S_LO),
      (state_q == S_HI): begin
        if (!last) begin
          cnt_d = cnt_q + 4'd1;
          mw_d  = wr_q && ((cnt_q + 4'd1) == LAST);
        end else if (state_q == S_LO && word_q) begin
          lo_d    = bus.mem_rdata;
          state_d = S_HI;
          cnt_d   = 4'd0;
          ma_d    = addr_q + 16'd1;
          mwd_d   = hi_q;
          mw_d    = wr_q & FIRST_WR;
        end else begin
          state_d = S_RESP;
          mr_d    = 1'b0;
          rv_d    = 1'b1;
          // hi phase result carries lo byte captured earlier
          if (wr_q)
            rd_d = 16'h0000;
          else if (state_q == S_HI)
            rd_d = {bus.mem_rdata, lo_q};
          else
            rd_d = {8'h00, bus.mem_rdata};
        end
      end
      (state_q == S_RESP): begin
        state_d = S_IDLE;
        rdy_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= 16'h0000;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      rdy_q   <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= 16'h0000;
      ma_q    <= 16'h0000;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      mwd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      ma_q    <= ma_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      mwd_q   <= mwd_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rd_q;
  assign bus.mem_addr  = ma_q;
  assign bus.mem_read  = mr_q;
  assign bus.mem_write = mw_q;
  assign bus.mem_wdata = mwd_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: two controllers (WAIT 0 and 2) on RAM
// models, checked each cycle against a transaction-level model.
module tb_mem_access_ctrl;
  logic clk;
  logic rst_n;

  mem_access_if b0 ();
  mem_access_if b1 ();

  mem_access_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  mem_access_ctrl #(.WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic [7:0] ram0 [65536];
  logic [7:0] ram1 [65536];
  bit ram_ok0, ram_ok1;

  assign b0.mem_rdata = ram0[b0.mem_addr];
  assign b1.mem_rdata = ram1[b1.mem_addr];

  always @(posedge clk) begin
    if (!ram_ok0) begin
      for (int j = 0; j < 65536; j++) ram0[j] <= f(16'(j));
      ram_ok0 <= 1'b1;
    end else if (b0.mem_write) begin
      ram0[b0.mem_addr] <= b0.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (!ram_ok1) begin
      for (int j = 0; j < 65536; j++) ram1[j] <= f(16'(j));
      ram_ok1 <= 1'b1;
    end else if (b1.mem_write) begin
      ram1[b1.mem_addr] <= b1.mem_wdata;
    end
  end

  // accepted requests, captured at the handshake edge
  int          acc_cnt [2];
  logic        a_wr    [2];
  logic        a_word  [2];
  logic [15:0] a_addr  [2];
  logic [15:0] a_wd    [2];
  int          re_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      re_cnt <= 0;
    end else begin
      re_cnt <= re_cnt + 1;
      if (b0.req_valid && b0.req_ready) begin
        acc_cnt[0] <= acc_cnt[0] + 1;
        a_wr[0]    <= b0.req_write;
        a_word[0]  <= b0.req_word;
        a_addr[0]  <= b0.req_addr;
        a_wd[0]    <= b0.req_wdata;
      end
      if (b1.req_valid && b1.req_ready) begin
        acc_cnt[1] <= acc_cnt[1] + 1;
        a_wr[1]    <= b1.req_write;
        a_word[1]  <= b1.req_word;
        a_addr[1]  <= b1.req_addr;
        a_wd[1]    <= b1.req_wdata;
      end
    end
  end

  // reference model state
  logic [7:0]  mdl [2][65536];
  bit          mdl_ok;
  bit          busy   [2];
  int          c      [2];
  int          seen   [2];
  logic        t_wr   [2];
  logic        t_word [2];
  logic [15:0] t_addr [2];
  logic [15:0] t_wd   [2];
  int          t_idx  [2];
  logic [15:0] e_addr [2];
  logic [7:0]  e_wd   [2];
  logic [15:0] e_rd   [2];
  int          pin_rd  [2][1024];
  int          pin_lat [2][1024];
  int          to_cnt, to_seen;
  int          vecs, errs;

  function automatic void chk(input int i, input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL inst%0d %s: got %0h, required %0h",
               i, nm, act, exp);
    end
  endfunction

  task automatic step(input int i, input logic rdy,
                      input logic rv, input logic [15:0] rd,
                      input logic [15:0] ma, input logic mr,
                      input logic mw, input logic [7:0] wd);
    int w, p, k, l, ph, pos, n;
    logic [15:0] a0, a1;
    logic [7:0] b;
    logic x_rdy, x_rv, x_mr, x_mw;
    w = (i == 0) ? 0 : 2;
    p = w + 1;
    x_rdy = 1'b0; x_rv = 1'b0; x_mr = 1'b0; x_mw = 1'b0;
    if (!rst_n) begin
      busy[i] = 1'b0;
      e_addr[i] = 16'h0; e_wd[i] = 8'h0; e_rd[i] = 16'h0;
      seen[i] = acc_cnt[i];
    end else begin
      if (acc_cnt[i] != seen[i]) begin
        seen[i] = acc_cnt[i];
        busy[i] = 1'b1; c[i] = 0;
        t_wr[i] = a_wr[i]; t_word[i] = a_word[i];
        t_addr[i] = a_addr[i]; t_wd[i] = a_wd[i];
        t_idx[i] = acc_cnt[i] - 1;
      end
      if (busy[i]) begin
        c[i]++;
        k = t_word[i] ? 2 : 1;
        l = k * p;
        a0 = t_addr[i];
        a1 = a0 + 16'd1;
        if (c[i] <= l) begin
          ph = (c[i] - 1) / p;
          pos = (c[i] - 1) % p;
          e_addr[i] = (ph == 1) ? a1 : a0;
          b = (ph == 1) ? t_wd[i][15:8] : t_wd[i][7:0];
          e_wd[i] = b;
          x_mr = !t_wr[i];
          x_mw = t_wr[i] && (pos == p - 1);
          if (x_mw) mdl[i][e_addr[i]] = b;
        end else begin
          x_rv = 1'b1;
          busy[i] = 1'b0;
          if (t_wr[i]) e_rd[i] = 16'h0;
          else if (t_word[i]) e_rd[i] = {mdl[i][a1], mdl[i][a0]};
          else e_rd[i] = {8'h00, mdl[i][a0]};
          n = t_idx[i] % 1024;
          if (pin_rd[i][n] >= 0)
            chk(i, "rdata_literal", 32'(rd), 32'(pin_rd[i][n]));
          if (pin_lat[i][n] >= 0)
            chk(i, "latency_literal", 32'(c[i]), 32'(pin_lat[i][n]));
        end
      end else begin
        x_rdy = (re_cnt > 0);
      end
    end
    chk(i, "req_ready", 32'(rdy), 32'(x_rdy));
    chk(i, "rsp_valid", 32'(rv), 32'(x_rv));
    chk(i, "rsp_rdata", 32'(rd), 32'(e_rd[i]));
    chk(i, "mem_addr", 32'(ma), 32'(e_addr[i]));
    chk(i, "mem_read", 32'(mr), 32'(x_mr));
    chk(i, "mem_write", 32'(mw), 32'(x_mw));
    chk(i, "mem_wdata", 32'(wd), 32'(e_wd[i]));
  endtask

  always @(negedge clk) begin
    if (!mdl_ok) begin
      for (int j = 0; j < 65536; j++) begin
        mdl[0][j] = f(16'(j));
        mdl[1][j] = f(16'(j));
      end
      mdl_ok = 1'b1;
    end
    if (to_cnt != to_seen) begin
      to_seen = to_cnt;
      vecs++;
      errs++;
    end
    step(0, b0.req_ready, b0.rsp_valid, b0.rsp_rdata,
         b0.mem_addr, b0.mem_read, b0.mem_write, b0.mem_wdata);
    step(1, b1.req_ready, b1.rsp_valid, b1.rsp_rdata,
         b1.mem_addr, b1.mem_read, b1.mem_write, b1.mem_wdata);
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic v,
                         input logic wr, input logic wo,
                         input logic [15:0] a,
                         input logic [15:0] d);
    if (i == 0) begin
      b0.req_valid = v; b0.req_write = wr; b0.req_word = wo;
      b0.req_addr = a; b0.req_wdata = d;
    end else begin
      b1.req_valid = v; b1.req_write = wr; b1.req_word = wo;
      b1.req_addr = a; b1.req_wdata = d;
    end
  endtask

  task automatic wait_acc(input int i, input int idx);
    int n;
    n = 0;
    while (acc_cnt[i] == idx && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (acc_cnt[i] == idx) begin
      $display("FAIL inst%0d accept_timeout: got none, required one",
               i);
      to_cnt++;
    end
  endtask

  task automatic issue(input int i, input logic wr,
                       input logic wo, input logic [15:0] a,
                       input logic [15:0] d, input int pr,
                       input int pl);
    int idx, w;
    w = (i == 0) ? 0 : 2;
    idx = acc_cnt[i];
    pin_rd[i][idx % 1024] = pr;
    pin_lat[i][idx % 1024] = pl;
    set_req(i, 1'b1, wr, wo, a, d);
    wait_acc(i, idx);
    set_req(i, 1'b0, ~wr, ~wo, ~a, ~d);
    repeat (2 * (w + 1) + 3) @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 16'hFFFF;
    return {12'h300, 4'($urandom_range(0, 15))};
  endfunction

  initial begin
    int idx;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 1024; j++) begin
        pin_rd[i][j] = -1;
        pin_lat[i][j] = -1;
      end
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    issue(0, 1'b1, 1'b0, 16'h0010, 16'h005A, 0, 2);
    issue(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h005A, 2);
    issue(0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 0, 3);
    issue(0, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'hBEEF, 3);
    issue(0, 1'b0, 1'b0, 16'h1235, 16'h0000, 16'h00BE, 2);
    issue(0, 1'b1, 1'b1, 16'hFFFF, 16'hA55A, 0, 3);
    issue(0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hA55A, 3);
    issue(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00A5, 2);
    issue(1, 1'b1, 1'b1, 16'h2000, 16'h1357, 0, 7);
    issue(1, 1'b0, 1'b1, 16'h2000, 16'h0000, 16'h1357, 7);
    issue(1, 1'b0, 1'b0, 16'h2001, 16'h0000, 16'h0013, 4);

    for (int n = 0; n < 400; n++) begin
      set_req(0, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rnd_addr(), 16'($urandom));
      set_req(1, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rnd_addr(), 16'($urandom));
      @(posedge clk); #2;
    end
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (10) @(posedge clk);
    #2;

    // abort a word write during its high-byte phase
    idx = acc_cnt[0];
    set_req(0, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h1122);
    wait_acc(0, idx);
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    issue(0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h7D22, 3);
    issue(1, 1'b0, 1'b1, 16'h2000, 16'h0000, 16'h1357, 7);

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
